pixel_scan_gen: RTL and testbench

Downstream of the zoom/coordinate unit. Takes the current view's top-left real coordinates and zoom level and walks every screen pixel in raster order. For each pixel it emits the complex constant c = (c_re, c_im) in signed Q21/N32 fixed point, plus pixel indices, to the Mandelbrot iteration engine over a valid/ready stream. Coordinates are built by incremental accumulation (adds only, no multipliers).

---
 rtl/mandel_pkg.sv | 24 ++
 rtl/pixel_scan_gen_if.sv | 15 +
 rtl/coord_acc.sv | 35 +++
 rtl/pixel_scan_gen.sv | 152 +++++++++++++++
 tb/tb_pixel_scan_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared constants, state encodings and helpers for the Mandelbrot pixel pipeline.
// Coordinates are signed Q21 in an N-bit word.
package mandel_pkg;

  localparam int unsigned Q     = 21;
  localparam int unsigned N     = 32;
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;
  localparam int unsigned PIX_W = 16;

  localparam logic [N-1:0] STEP0  = 32'h0000_2666;
  localparam logic [N-1:0] DEF_RE = 32'hFFC0_0000; // -2.0
  localparam logic [N-1:0] DEF_IM = 32'h0025_8000; // 1.171875

  typedef enum logic [1:0] {StIdle, StScan, StDone} scan_state_e;

  typedef enum logic [1:0] {AccHold, AccLoad, AccAdd, AccSub} acc_op_e;

  // Each zoom level halves the per-pixel step.
  function automatic logic [N-1:0] zoom_step(input logic [1:0] level);
    return STEP0 >> level;
  endfunction

endpackage

// File: rtl/pixel_scan_gen_if.sv
// Pixel coordinate stream from the scan generator to the iteration engine.
interface pixel_scan_gen_if;
  import mandel_pkg::*;

  logic [N-1:0]     c_re;
  logic [N-1:0]     c_im;
  logic [PIX_W-1:0] pix_x;
  logic [PIX_W-1:0] pix_y;
  logic             c_valid;
  logic             c_ready;

  modport master (output c_re, c_im, pix_x, pix_y, c_valid, input c_ready);
  modport slave  (input c_re, c_im, pix_x, pix_y, c_valid, output c_ready);

endinterface

// File: rtl/coord_acc.sv
// N-bit coordinate accumulator: hold, load, add step or subtract step each cycle.
module coord_acc
  import mandel_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  acc_op_e      op_i,
  input  logic [N-1:0] load_val_i,
  input  logic [N-1:0] step_i,
  output logic [N-1:0] acc_o
);

  logic [N-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    case (op_i)
      AccLoad: acc_d = load_val_i;
      AccAdd:  acc_d = acc_q + step_i;
      AccSub:  acc_d = acc_q - step_i;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster-order pixel walker: emits c = (re, im) per screen pixel using adds only.
// A view change mid-frame restarts the scan at (0,0) with the new view.
module pixel_scan_gen
  import mandel_pkg::*;
#(
  parameter int unsigned HRes = H_RES,
  parameter int unsigned VRes = V_RES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N-1:0]            base_re,
  input  logic [N-1:0]            base_im,
  input  logic [1:0]              zoom_level,
  pixel_scan_gen_if.master        stream,
  output logic                    busy,
  output logic                    frame_done
);

  scan_state_e      state_d, state_q;
  logic [N-1:0]     base_re_d, base_re_q;
  logic [N-1:0]     base_im_d, base_im_q;
  logic [1:0]       zoom_d, zoom_q;
  logic             pend_d, pend_q;
  logic             valid_d, valid_q;
  logic [PIX_W-1:0] x_d, x_q;
  logic [PIX_W-1:0] y_d, y_q;

  acc_op_e      re_op, im_op;
  logic [N-1:0] re_load;
  logic [N-1:0] step;
  logic [N-1:0] c_re_w, c_im_w;
  logic         xfer, view_diff, last_col, last_row;

  assign step      = zoom_step(zoom_q);
  assign xfer      = valid_q & stream.c_ready;
  assign view_diff = (base_re != base_re_q) || (base_im != base_im_q) || (zoom_level != zoom_q);
  assign last_col  = (x_q == PIX_W'(HRes - 1));
  assign last_row  = (y_q == PIX_W'(VRes - 1));

  always_comb begin
    state_d   = state_q;
    base_re_d = base_re_q;
    base_im_d = base_im_q;
    zoom_d    = zoom_q;
    pend_d    = pend_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    re_op     = AccHold;
    im_op     = AccHold;
    re_load   = base_re_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          base_re_d = base_re;
          base_im_d = base_im;
          zoom_d    = zoom_level;
          pend_d    = 1'b0;
          valid_d   = 1'b1;
          x_d       = '0;
          y_d       = '0;
          re_load   = base_re;
          re_op     = AccLoad;
          im_op     = AccLoad;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (view_diff) pend_d = 1'b1;
        // A pending restart takes priority over normal advance, including the last pixel.
        if ((pend_q || view_diff) && (xfer || !valid_q)) begin
          base_re_d = base_re;
          base_im_d = base_im;
          zoom_d    = zoom_level;
          pend_d    = 1'b0;
          valid_d   = 1'b1;
          x_d       = '0;
          y_d       = '0;
          re_load   = base_re;
          re_op     = AccLoad;
          im_op     = AccLoad;
        end else if (xfer) begin
          if (!last_col) begin
            x_d   = x_q + 1'b1;
            re_op = AccAdd;
          end else if (!last_row) begin
            x_d   = '0;
            y_d   = y_q + 1'b1;
            re_op = AccLoad;
            im_op = AccSub;
          end else begin
            valid_d = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      base_re_q <= '0;
      base_im_q <= '0;
      zoom_q    <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      base_re_q <= base_re_d;
      base_im_q <= base_im_d;
      zoom_q    <= zoom_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  coord_acc u_acc_re (
    .clk_i      (clk),
    .rst_ni     (rst),
    .op_i       (re_op),
    .load_val_i (re_load),
    .step_i     (step),
    .acc_o      (c_re_w)
  );

  coord_acc u_acc_im (
    .clk_i      (clk),
    .rst_ni     (rst),
    .op_i       (im_op),
    .load_val_i (base_im),
    .step_i     (step),
    .acc_o      (c_im_w)
  );

  assign stream.c_re    = c_re_w;
  assign stream.c_im    = c_im_w;
  assign stream.pix_x   = x_q;
  assign stream.pix_y   = y_q;
  assign stream.c_valid = valid_q;
  assign busy           = (state_q != StIdle);
  assign frame_done     = (state_q == StDone);

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen with a short frame (640 x 4) to keep runs brief.
module tb_pixel_scan_gen;

  localparam int H     = 640;
  localparam int V     = 4;
  localparam int FRAME = H * V;
  localparam logic [31:0] DRE = 32'hFFC0_0000;
  localparam logic [31:0] DIM = 32'h0025_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_re, base_im;
  logic [1:0]  zoom_level;
  logic        busy, frame_done;

  int checks = 0;
  int errors = 0;

  pixel_scan_gen_if sif ();

  pixel_scan_gen #(.HRes(H), .VRes(V)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_re    (base_re),
    .base_im    (base_im),
    .zoom_level (zoom_level),
    .stream     (sif),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  zoom;
    logic [31:0] bre, bim;
    int          beat;
    logic [15:0] x, y;
    logic [31:0] re, im;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    start = 1'b0;
    step_clk();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  initial begin
    int cnt, cyc, xfers, fd, last_s, fd_s;
    logic found;
    logic [15:0] ex, ey, hx, hy;
    logic [31:0] hre, him, ere, eim;

    vecs[0] = '{2'd0, DRE, DIM, 0,    16'd0,   16'd0, 32'hFFC0_0000, 32'h0025_8000};
    vecs[1] = '{2'd0, DRE, DIM, 1,    16'd1,   16'd0, 32'hFFC0_2666, 32'h0025_8000};
    vecs[2] = '{2'd0, DRE, DIM, 640,  16'd0,   16'd1, 32'hFFC0_0000, 32'h0025_599A};
    vecs[3] = '{2'd0, DRE, DIM, 2559, 16'd639, 16'd3, 32'h001F_D89A, 32'h0025_0CCE};
    vecs[4] = '{2'd1, DRE, DIM, 1,    16'd1,   16'd0, 32'hFFC0_1333, 32'h0025_8000};
    vecs[5] = '{2'd3, DRE, DIM, 641,  16'd1,   16'd1, 32'hFFC0_04CC, 32'h0025_7B34};
    vecs[6] = '{2'd2, DRE, DIM, 639,  16'd639, 16'd0, 32'hFFD7_F4E7, 32'h0025_8000};
    vecs[7] = '{2'd0, 32'h0010_0000, 32'hFFF0_0000, 641, 16'd1, 16'd1,
                32'h0010_2666, 32'hFFEF_D99A};

    rst         = 1'b0;
    start       = 1'b0;
    base_re     = DRE;
    base_im     = DIM;
    zoom_level  = 2'd0;
    sif.c_ready = 1'b1;
    step_clk();
    step_clk();

    // Reset state
    chk("rst_valid", 32'(sif.c_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_re", sif.c_re, 32'd0);
    chk("rst_im", sif.c_im, 32'd0);
    chk("rst_x", 32'(sif.pix_x), 32'd0);
    chk("rst_y", 32'(sif.pix_y), 32'd0);
    rst = 1'b1;

    // Table-driven beats
    for (int i = 0; i < 8; i++) begin
      do_reset();
      base_re     = vecs[i].bre;
      base_im     = vecs[i].bim;
      zoom_level  = vecs[i].zoom;
      sif.c_ready = 1'b1;
      pulse_start();
      cnt   = 0;
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < FRAME + 20) begin
        if (sif.c_valid && cnt == vecs[i].beat) begin
          found = 1'b1;
        end else begin
          if (sif.c_valid) cnt++;
          step_clk();
          cyc++;
        end
      end
      chk($sformatf("vec%0d_found", i), 32'(found), 32'd1);
      if (found) begin
        chk($sformatf("vec%0d_x", i), 32'(sif.pix_x), 32'(vecs[i].x));
        chk($sformatf("vec%0d_y", i), 32'(sif.pix_y), 32'(vecs[i].y));
        chk($sformatf("vec%0d_re", i), sif.c_re, vecs[i].re);
        chk($sformatf("vec%0d_im", i), sif.c_im, vecs[i].im);
      end
    end

    // Full frame: frame_done timing and busy fall
    do_reset();
    base_re = DRE; base_im = DIM; zoom_level = 2'd0; sif.c_ready = 1'b1;
    pulse_start();
    xfers = 0; fd = 0; last_s = -10; fd_s = -1;
    for (int s = 0; s < FRAME + 20; s++) begin
      if (sif.c_valid && sif.c_ready) begin
        xfers++;
        if (xfers == FRAME) begin
          last_s = s;
          chk("last_x", 32'(sif.pix_x), 32'd639);
          chk("last_y", 32'(sif.pix_y), 32'd3);
        end
      end
      if (frame_done) begin
        fd++;
        fd_s = s;
      end
      step_clk();
    end
    chk("frame_xfers", 32'(xfers), 32'(FRAME));
    chk("frame_done_cnt", 32'(fd), 32'd1);
    chk("frame_done_time", 32'(fd_s), 32'(last_s + 1));
    chk("busy_after", 32'(busy), 32'd0);

    // Backpressure, plus a start pulse while busy, against a scoreboard
    do_reset();
    base_re = DRE; base_im = DIM; zoom_level = 2'd0;
    pulse_start();
    xfers = 0; ex = 0; ey = 0; hx = 0; hy = 0; hre = 0; him = 0;
    for (int s = 0; s < FRAME + 30; s++) begin
      sif.c_ready = !(s >= 100 && s < 105);
      start       = (s == 300);
      if (s == 100) begin
        hx = sif.pix_x; hy = sif.pix_y; hre = sif.c_re; him = sif.c_im;
      end
      if (s > 100 && s <= 105) begin
        chk("stall_x", 32'(sif.pix_x), 32'(hx));
        chk("stall_y", 32'(sif.pix_y), 32'(hy));
        chk("stall_re", sif.c_re, hre);
        chk("stall_im", sif.c_im, him);
        chk("stall_valid", 32'(sif.c_valid), 32'd1);
      end
      if (sif.c_valid && sif.c_ready) begin
        ere = DRE + 32'(ex) * 32'h2666;
        eim = DIM - 32'(ey) * 32'h2666;
        checks++;
        if (sif.pix_x !== ex || sif.pix_y !== ey || sif.c_re !== ere || sif.c_im !== eim) begin
          errors++;
          $display("FAIL bp_beat%0d: got (%0d,%0d) %08h %08h, want (%0d,%0d) %08h %08h",
                   xfers, sif.pix_x, sif.pix_y, sif.c_re, sif.c_im, ex, ey, ere, eim);
        end
        xfers++;
        if (ex == 16'(H - 1)) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end
      step_clk();
    end
    start = 1'b0;
    sif.c_ready = 1'b1;
    chk("bp_xfers", 32'(xfers), 32'(FRAME));

    // Zoom change mid-frame restarts the scan
    do_reset();
    base_re = DRE; base_im = DIM; zoom_level = 2'd0; sif.c_ready = 1'b1;
    pulse_start();
    xfers = 0; fd = 0;
    for (int s = 0; s < FRAME + 100; s++) begin
      if (s == 50) zoom_level = 2'd1;
      if (s == 51) begin
        chk("zc_valid", 32'(sif.c_valid), 32'd1);
        chk("zc_x", 32'(sif.pix_x), 32'd0);
        chk("zc_y", 32'(sif.pix_y), 32'd0);
        chk("zc_re", sif.c_re, DRE);
        chk("zc_im", sif.c_im, DIM);
      end
      if (s == 52) begin
        chk("zc_x1", 32'(sif.pix_x), 32'd1);
        chk("zc_re1", sif.c_re, 32'hFFC0_1333);
      end
      if (s >= 51 && sif.c_valid && sif.c_ready) xfers++;
      if (frame_done) fd++;
      step_clk();
    end
    chk("zc_xfers", 32'(xfers), 32'(FRAME));
    chk("zc_done_cnt", 32'(fd), 32'd1);

    // Reset mid-frame
    do_reset();
    base_re = DRE; base_im = DIM; zoom_level = 2'd0; sif.c_ready = 1'b1;
    pulse_start();
    repeat (30) step_clk();
    rst = 1'b0;
    step_clk();
    chk("mr_valid", 32'(sif.c_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(frame_done), 32'd0);
    chk("mr_re", sif.c_re, 32'd0);
    chk("mr_im", sif.c_im, 32'd0);
    chk("mr_x", 32'(sif.pix_x), 32'd0);
    rst = 1'b1;
    pulse_start();
    chk("mr_rs_valid", 32'(sif.c_valid), 32'd1);
    chk("mr_rs_x", 32'(sif.pix_x), 32'd0);
    chk("mr_rs_re", sif.c_re, DRE);
    step_clk();
    chk("mr_rs_re1", sif.c_re, 32'hFFC0_2666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
